// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared constants, encodings and CSR map for the M stage
// Contents: NOP bubble instruction, load/store width codes, CSR op codes,
// CSR addresses, and the CSR read-modify-write helper.
package rv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000033;  // ADD x0,x0,x0
    localparam int          CNT_W     = 64;

    // funct3 encodings shared by loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_FFLAGS   = 12'h001;
    localparam logic [11:0] CSR_FRM      = 12'h002;
    localparam logic [11:0] CSR_FCSR     = 12'h003;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;

    function automatic logic [31:0] csr_modify(input logic [1:0] op,
                                               input logic [31:0] old_val,
                                               input logic [31:0] src);
        logic [31:0] res;
        res = old_val;
        case (op)
            CSR_RW:  res = src;
            CSR_RS:  res = old_val | src;
            CSR_RC:  res = old_val & ~src;
            default: res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_file.sv
// rtl/csr_file.sv - frm/fflags and cycle/instret counter CSRs
// Ports: clk_i/reset_i (async active-low), csr_addr (read/write address),
// csr_rdata (combinational pre-write read), csr_we/csr_wdata (gated write),
// instret_inc (retire pulse), frm (current rounding mode).
module csr_file
    import rv_pkg::*;
#(
    parameter int CNT_W_P = CNT_W
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [11:0] csr_addr,
    output logic [31:0] csr_rdata,
    input  logic        csr_we,
    input  logic [31:0] csr_wdata,
    input  logic        instret_inc,
    output logic [2:0]  frm
);

    logic [4:0]         fflags;
    logic [2:0]         frm_q;
    logic [CNT_W_P-1:0] cycle;
    logic [CNT_W_P-1:0] instret;

    assign frm = frm_q;

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            CSR_FFLAGS:   csr_rdata = {27'h0, fflags};
            CSR_FRM:      csr_rdata = {29'h0, frm_q};
            CSR_FCSR:     csr_rdata = {24'h0, frm_q, fflags};
            CSR_CYCLE:    csr_rdata = cycle[31:0];
            CSR_CYCLEH:   csr_rdata = cycle[CNT_W_P-1:32];
            CSR_INSTRET:  csr_rdata = instret[31:0];
            CSR_INSTRETH: csr_rdata = instret[CNT_W_P-1:32];
            default:      csr_rdata = 32'h0;
        endcase
    end

    // The increments are issued first so that a same-cycle write to a
    // counter half overrides them; the untouched half keeps its old value,
    // which drops any carry out of a written low half.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            fflags  <= 5'h0;
            frm_q   <= 3'h0;
            cycle   <= '0;
            instret <= '0;
        end else begin
            cycle <= cycle + CNT_W_P'(1);
            if (instret_inc) begin
                instret <= instret + CNT_W_P'(1);
            end
            if (csr_we) begin
                case (csr_addr)
                    CSR_FFLAGS:   fflags  <= csr_wdata[4:0];
                    CSR_FRM:      frm_q   <= csr_wdata[2:0];
                    CSR_FCSR: begin
                        frm_q  <= csr_wdata[7:5];
                        fflags <= csr_wdata[4:0];
                    end
                    CSR_CYCLE:    cycle   <= {cycle[CNT_W_P-1:32], csr_wdata};
                    CSR_CYCLEH:   cycle   <= {csr_wdata, cycle[31:0]};
                    CSR_INSTRET:  instret <= {instret[CNT_W_P-1:32], csr_wdata};
                    CSR_INSTRETH: instret <= {csr_wdata, instret[31:0]};
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/memory_unit.sv
// rtl/memory_unit.sv - pipeline M stage: store lanes, load extension, CSR access, MW register
// Ports: clk_i/reset_i (async active-low); M_stall_i/W_flush_i control;
// EM_* execute-to-memory register inputs; DMemW* data-memory store port;
// csrFRM_o rounding mode to execute; MW_* memory-to-writeback register.
module memory_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] NOP   = NOP_INSTR,
    parameter int          CNT_W = rv_pkg::CNT_W
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        M_stall_i,
    input  logic        W_flush_i,
    input  logic [31:0] EM_PC_i,
    input  logic [31:0] EM_instr_i,
    input  logic        EM_nop_i,
    input  logic        EM_isLoad_i,
    input  logic        EM_isStore_i,
    input  logic        EM_isCSR_i,
    input  logic [5:0]  EM_rdId_i,
    input  logic [5:0]  EM_rs1Id_i,
    input  logic [11:0] EM_csrId_i,
    input  logic [2:0]  EM_funct3_i,
    input  logic [31:0] EM_rs1_i,
    input  logic [31:0] EM_rs2_i,
    input  logic [31:0] EM_Eresult_i,
    input  logic [31:0] EM_addr_i,
    input  logic [31:0] EM_Mdata_i,
    input  logic        EM_wbEnable_i,
    output logic [31:0] DMemWAddr_o,
    output logic [31:0] DMemWData_o,
    output logic [3:0]  DMemWMask_o,
    output logic [2:0]  csrFRM_o,
    output logic [31:0] MW_PC_o,
    output logic [31:0] MW_instr_o,
    output logic        MW_nop_o,
    output logic        MW_wbEnable_o,
    output logic [5:0]  MW_rdId_o,
    output logic [31:0] MW_wbData_o
);

    logic        adv;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;
    logic [31:0] csr_src;
    logic [31:0] csr_rdata;
    logic [31:0] csr_wdata;
    logic        csr_we;
    logic [1:0]  csr_op;
    logic [31:0] wb_data;
    logic        unused_rs1_fp;

    // Stalled or bubble instructions must not produce side effects.
    assign adv           = !M_stall_i && !EM_nop_i;
    assign unused_rs1_fp = EM_rs1Id_i[5];

    // Store lanes: memory is word-addressed, so the data is replicated
    // across lanes and the mask picks the bytes that land.
    assign DMemWAddr_o = {EM_addr_i[31:2], 2'b00};

    always_comb begin
        DMemWMask_o = 4'b0000;
        DMemWData_o = EM_rs2_i;
        case (EM_funct3_i)
            F3_B:    DMemWData_o = {4{EM_rs2_i[7:0]}};
            F3_H:    DMemWData_o = {2{EM_rs2_i[15:0]}};
            default: DMemWData_o = EM_rs2_i;
        endcase
        if (EM_isStore_i && adv) begin
            case (EM_funct3_i)
                F3_B:    DMemWMask_o = 4'b0001 << EM_addr_i[1:0];
                F3_H:    DMemWMask_o = 4'b0011 << {EM_addr_i[1], 1'b0};
                F3_W:    DMemWMask_o = 4'b1111;
                default: DMemWMask_o = 4'b0000;
            endcase
        end
    end

    // Load extraction from the word fetched with the E-stage address.
    assign ld_byte = EM_Mdata_i[{EM_addr_i[1:0], 3'b000} +: 8];
    assign ld_half = EM_Mdata_i[{EM_addr_i[1], 4'b0000} +: 16];

    always_comb begin
        load_val = EM_Mdata_i;
        case (EM_funct3_i)
            F3_B:    load_val = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    load_val = {{16{ld_half[15]}}, ld_half};
            F3_BU:   load_val = {24'h0, ld_byte};
            F3_HU:   load_val = {16'h0, ld_half};
            default: load_val = EM_Mdata_i;
        endcase
    end

    // CSR access: set/clear with a zero source is a pure read.
    assign csr_op    = EM_funct3_i[1:0];
    assign csr_src   = EM_funct3_i[2] ? {27'h0, EM_rs1Id_i[4:0]} : EM_rs1_i;
    assign csr_wdata = csr_modify(csr_op, csr_rdata, csr_src);
    assign csr_we    = EM_isCSR_i && adv &&
                       ((csr_op == CSR_RW) ||
                        ((csr_op != CSR_NONE) && (csr_src != 32'h0)));

    csr_file #(
        .CNT_W_P(CNT_W)
    ) u_csr_file (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .csr_addr   (EM_csrId_i),
        .csr_rdata  (csr_rdata),
        .csr_we     (csr_we),
        .csr_wdata  (csr_wdata),
        .instret_inc(adv),
        .frm        (csrFRM_o)
    );

    assign wb_data = EM_isLoad_i ? load_val :
                     EM_isCSR_i  ? csr_rdata : EM_Eresult_i;

    // MW register; flush overrides stall and inserts a bubble.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            MW_PC_o       <= 32'h0;
            MW_instr_o    <= NOP;
            MW_nop_o      <= 1'b1;
            MW_wbEnable_o <= 1'b0;
            MW_rdId_o     <= 6'h0;
            MW_wbData_o   <= 32'h0;
        end else if (W_flush_i) begin
            MW_PC_o       <= 32'h0;
            MW_instr_o    <= NOP;
            MW_nop_o      <= 1'b1;
            MW_wbEnable_o <= 1'b0;
            MW_rdId_o     <= 6'h0;
            MW_wbData_o   <= 32'h0;
        end else if (!M_stall_i) begin
            MW_PC_o       <= EM_PC_i;
            MW_instr_o    <= EM_instr_i;
            MW_nop_o      <= EM_nop_i;
            MW_wbEnable_o <= EM_wbEnable_i && (EM_rdId_i != 6'h0);
            MW_rdId_o     <= EM_rdId_i;
            MW_wbData_o   <= wb_data;
        end
    end

endmodule

// File: tb/tb_memory_unit.sv
// tb/tb_memory_unit.sv - scoreboard testbench for memory_unit
module tb_memory_unit;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        M_stall_i, W_flush_i;
    logic [31:0] EM_PC_i, EM_instr_i;
    logic        EM_nop_i, EM_isLoad_i, EM_isStore_i, EM_isCSR_i;
    logic [5:0]  EM_rdId_i, EM_rs1Id_i;
    logic [11:0] EM_csrId_i;
    logic [2:0]  EM_funct3_i;
    logic [31:0] EM_rs1_i, EM_rs2_i, EM_Eresult_i, EM_addr_i, EM_Mdata_i;
    logic        EM_wbEnable_i;
    logic [31:0] DMemWAddr_o, DMemWData_o;
    logic [3:0]  DMemWMask_o;
    logic [2:0]  csrFRM_o;
    logic [31:0] MW_PC_o, MW_instr_o, MW_wbData_o;
    logic        MW_nop_o, MW_wbEnable_o;
    logic [5:0]  MW_rdId_o;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [5:0]  rd;
        logic        wbe;
        logic [31:0] data;
        logic        chk_data;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          n_ret    = 0;
    logic [31:0] last_pc  = 32'h0;

    memory_unit dut (
        .clk_i(clk_i), .reset_i(reset_i), .M_stall_i(M_stall_i), .W_flush_i(W_flush_i),
        .EM_PC_i(EM_PC_i), .EM_instr_i(EM_instr_i), .EM_nop_i(EM_nop_i),
        .EM_isLoad_i(EM_isLoad_i), .EM_isStore_i(EM_isStore_i), .EM_isCSR_i(EM_isCSR_i),
        .EM_rdId_i(EM_rdId_i), .EM_rs1Id_i(EM_rs1Id_i), .EM_csrId_i(EM_csrId_i),
        .EM_funct3_i(EM_funct3_i), .EM_rs1_i(EM_rs1_i), .EM_rs2_i(EM_rs2_i),
        .EM_Eresult_i(EM_Eresult_i), .EM_addr_i(EM_addr_i), .EM_Mdata_i(EM_Mdata_i),
        .EM_wbEnable_i(EM_wbEnable_i),
        .DMemWAddr_o(DMemWAddr_o), .DMemWData_o(DMemWData_o), .DMemWMask_o(DMemWMask_o),
        .csrFRM_o(csrFRM_o), .MW_PC_o(MW_PC_o), .MW_instr_o(MW_instr_o),
        .MW_nop_o(MW_nop_o), .MW_wbEnable_o(MW_wbEnable_o), .MW_rdId_o(MW_rdId_o),
        .MW_wbData_o(MW_wbData_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: each new non-bubble MW entry is matched against the scoreboard.
    always @(negedge clk_i) begin
        if (!reset_i) begin
            last_pc = 32'h0;
        end else if (!MW_nop_o && MW_PC_o != last_pc) begin
            last_pc = MW_PC_o;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected pc actual=0x%08h required=none", MW_PC_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (MW_PC_o !== e.pc || MW_instr_o !== e.instr ||
                    MW_rdId_o !== e.rd || MW_wbEnable_o !== e.wbe) begin
                    failures++;
                    $display("FAIL sb_ctrl pc/instr/rd/wbe actual=%h/%h/%h/%b required=%h/%h/%h/%b",
                             MW_PC_o, MW_instr_o, MW_rdId_o, MW_wbEnable_o,
                             e.pc, e.instr, e.rd, e.wbe);
                end
                if (e.chk_data) begin
                    checks++;
                    if (MW_wbData_o !== e.data) begin
                        failures++;
                        $display("FAIL sb_data pc=%h actual=0x%08h required=0x%08h",
                                 e.pc, MW_wbData_o, e.data);
                    end
                end
            end
        end
    end

    task automatic idle();
        EM_PC_i = 32'h0; EM_instr_i = 32'h00000033; EM_nop_i = 1'b1;
        EM_isLoad_i = 1'b0; EM_isStore_i = 1'b0; EM_isCSR_i = 1'b0;
        EM_rdId_i = 6'h0; EM_rs1Id_i = 6'h0; EM_csrId_i = 12'h0; EM_funct3_i = 3'h0;
        EM_rs1_i = 32'h0; EM_rs2_i = 32'h0; EM_Eresult_i = 32'h0; EM_addr_i = 32'h0;
        EM_Mdata_i = 32'h0; EM_wbEnable_i = 1'b0;
    endtask

    task automatic base(input logic [31:0] pc);
        idle();
        EM_nop_i = 1'b0; EM_PC_i = pc; EM_instr_i = 32'h1000_0000 | pc;
    endtask

    task automatic op_alu(input logic [31:0] pc, input logic [5:0] rd, input logic [31:0] res);
        base(pc); EM_rdId_i = rd; EM_wbEnable_i = 1'b1; EM_Eresult_i = res;
    endtask

    task automatic op_store(input logic [31:0] pc, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] rs2);
        base(pc); EM_isStore_i = 1'b1; EM_funct3_i = f3; EM_addr_i = addr;
        EM_Eresult_i = addr; EM_rs2_i = rs2;
    endtask

    task automatic op_load(input logic [31:0] pc, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] mdata);
        base(pc); EM_isLoad_i = 1'b1; EM_funct3_i = f3; EM_addr_i = addr;
        EM_Eresult_i = addr; EM_Mdata_i = mdata; EM_rdId_i = 6'd5; EM_wbEnable_i = 1'b1;
    endtask

    task automatic op_csr(input logic [31:0] pc, input logic [2:0] f3, input logic [11:0] csr,
                          input logic [5:0] rs1id, input logic [31:0] rs1, input logic [5:0] rd);
        base(pc); EM_isCSR_i = 1'b1; EM_funct3_i = f3; EM_csrId_i = csr;
        EM_rs1Id_i = rs1id; EM_rs1_i = rs1; EM_rdId_i = rd; EM_wbEnable_i = 1'b1;
    endtask

    // Issue the instruction currently on the EM inputs for one clock.
    task automatic launch(input logic [31:0] exp_data, input logic chk_data, input logic exp_wbe);
        exp_t e;
        e.pc = EM_PC_i; e.instr = EM_instr_i; e.rd = EM_rdId_i; e.wbe = exp_wbe;
        e.data = exp_data; e.chk_data = chk_data;
        sb.push_back(e);
        n_ret++;
        @(posedge clk_i); #1;
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        idle(); M_stall_i = 1'b0; W_flush_i = 1'b0; reset_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_instr", MW_instr_o, 32'h00000033);
        chk("rst_nop", {31'h0, MW_nop_o}, 32'h1);
        chk("rst_wbe", {31'h0, MW_wbEnable_o}, 32'h0);
        chk("rst_data", MW_wbData_o, 32'h0);
        chk("rst_pc", MW_PC_o, 32'h0);
        chk("rst_rd", {26'h0, MW_rdId_o}, 32'h0);
        chk("rst_frm", {29'h0, csrFRM_o}, 32'h0);
        chk("rst_mask", {28'h0, DMemWMask_o}, 32'h0);
        reset_i = 1'b1;
        @(posedge clk_i); #1;

        // Stores
        op_store(32'h100, 3'b000, 32'h1003, 32'h000000A5); #1;
        chk("sb_mask", {28'h0, DMemWMask_o}, 32'h8);
        chk("sb_wdata", DMemWData_o, 32'hA5A5A5A5);
        chk("sb_waddr", DMemWAddr_o, 32'h1000);
        launch(32'h1003, 1'b1, 1'b0);
        op_store(32'h104, 3'b001, 32'h1002, 32'h1234BEEF); #1;
        chk("sh_mask", {28'h0, DMemWMask_o}, 32'hC);
        chk("sh_wdata", DMemWData_o, 32'hBEEFBEEF);
        launch(32'h1002, 1'b1, 1'b0);
        op_store(32'h108, 3'b010, 32'h1001, 32'hCAFEF00D); #1;
        chk("sw_mask", {28'h0, DMemWMask_o}, 32'hF);
        chk("sw_wdata", DMemWData_o, 32'hCAFEF00D);
        chk("sw_waddr", DMemWAddr_o, 32'h1000);
        launch(32'h1001, 1'b1, 1'b0);
        op_store(32'h10C, 3'b011, 32'h1000, 32'h11111111); #1;
        chk("bad_f3_mask", {28'h0, DMemWMask_o}, 32'h0);
        launch(32'h1000, 1'b1, 1'b0);

        // Loads and ALU results
        op_load(32'h200, 3'b001, 32'h2002, 32'h80011234); #1;
        chk("load_mask", {28'h0, DMemWMask_o}, 32'h0);
        launch(32'hFFFF8001, 1'b1, 1'b1);
        op_load(32'h204, 3'b101, 32'h2002, 32'h80011234); launch(32'h00008001, 1'b1, 1'b1);
        op_load(32'h208, 3'b100, 32'h2001, 32'h80011234); launch(32'h00000012, 1'b1, 1'b1);
        op_load(32'h20C, 3'b000, 32'h2003, 32'h80011234); launch(32'hFFFFFF80, 1'b1, 1'b1);
        op_load(32'h210, 3'b010, 32'h2000, 32'h80011234); launch(32'h80011234, 1'b1, 1'b1);
        op_alu(32'h220, 6'h21, 32'hDEADBEEF);             launch(32'hDEADBEEF, 1'b1, 1'b1);
        op_alu(32'h224, 6'h00, 32'h00000055);             launch(32'h00000055, 1'b1, 1'b0);

        // CSRs
        op_csr(32'h300, 3'b001, 12'h002, 6'd0, 32'd5, 6'd7);   launch(32'h0, 1'b1, 1'b1);
        chk("frm_after_rw", {29'h0, csrFRM_o}, 32'h5);
        op_csr(32'h304, 3'b010, 12'h003, 6'd0, 32'h0, 6'd7);   launch(32'hA0, 1'b1, 1'b1);
        chk("frm_after_rs0", {29'h0, csrFRM_o}, 32'h5);
        op_csr(32'h308, 3'b110, 12'h001, 6'd3, 32'h0, 6'd7);   launch(32'h0, 1'b1, 1'b1);
        op_csr(32'h30C, 3'b011, 12'h003, 6'd0, 32'h20, 6'd7);  launch(32'hA3, 1'b1, 1'b1);
        chk("frm_after_rc", {29'h0, csrFRM_o}, 32'h4);
        op_csr(32'h310, 3'b010, 12'h003, 6'd0, 32'h0, 6'd7);   launch(32'h83, 1'b1, 1'b1);
        op_csr(32'h314, 3'b001, 12'h7C0, 6'd0, 32'h1234, 6'd7); launch(32'h0, 1'b1, 1'b1);
        op_csr(32'h318, 3'b010, 12'h7C0, 6'd0, 32'h0, 6'd7);   launch(32'h0, 1'b1, 1'b1);

        // Stall across a store
        op_csr(32'h400, 3'b010, 12'hC02, 6'd0, 32'h0, 6'd8);   launch(n_ret, 1'b1, 1'b1);
        op_store(32'h404, 3'b010, 32'h3000, 32'h600DF00D);
        M_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_mask", {28'h0, DMemWMask_o}, 32'h0);
            @(posedge clk_i); #1;
            chk("stall_mw_pc", MW_PC_o, 32'h400);
        end
        M_stall_i = 1'b0; #1;
        chk("release_mask", {28'h0, DMemWMask_o}, 32'hF);
        launch(32'h3000, 1'b1, 1'b0);
        op_csr(32'h408, 3'b010, 12'hC02, 6'd0, 32'h0, 6'd8);   launch(n_ret, 1'b1, 1'b1);

        // Flush has priority over stall
        op_alu(32'h500, 6'd3, 32'h77);
        M_stall_i = 1'b1; W_flush_i = 1'b1;
        @(posedge clk_i); #1;
        chk("flush_nop", {31'h0, MW_nop_o}, 32'h1);
        chk("flush_wbe", {31'h0, MW_wbEnable_o}, 32'h0);
        chk("flush_instr", MW_instr_o, 32'h00000033);
        M_stall_i = 1'b0; W_flush_i = 1'b0; idle();

        // Cycle low-half write then carry into the high half
        op_csr(32'h600, 3'b001, 12'hC00, 6'd0, 32'hFFFFFFFF, 6'd0); launch(32'h0, 1'b0, 1'b0);
        op_csr(32'h604, 3'b010, 12'hC00, 6'd0, 32'h0, 6'd9); launch(32'hFFFFFFFF, 1'b1, 1'b1);
        op_csr(32'h608, 3'b010, 12'hC00, 6'd0, 32'h0, 6'd9); launch(32'h0, 1'b1, 1'b1);
        op_csr(32'h60C, 3'b010, 12'hC80, 6'd0, 32'h0, 6'd9); launch(32'h1, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a store
        op_store(32'h700, 3'b010, 32'h4000, 32'h12345678);
        @(negedge clk_i); #1;
        reset_i = 1'b0; #1;
        chk("mid_rst_nop", {31'h0, MW_nop_o}, 32'h1);
        chk("mid_rst_instr", MW_instr_o, 32'h00000033);
        chk("mid_rst_frm", {29'h0, csrFRM_o}, 32'h0);
        chk("mid_rst_wbe", {31'h0, MW_wbEnable_o}, 32'h0);
        @(posedge clk_i); #1;
        idle(); reset_i = 1'b1; n_ret = 0;
        @(posedge clk_i); #1;
        op_csr(32'h800, 3'b010, 12'hC02, 6'd0, 32'h0, 6'd9); launch(32'h0, 1'b1, 1'b1);
        op_csr(32'h804, 3'b010, 12'hC80, 6'd0, 32'h0, 6'd9); launch(32'h0, 1'b1, 1'b1);
        op_csr(32'h808, 3'b010, 12'h003, 6'd0, 32'h0, 6'd9); launch(32'h0, 1'b1, 1'b1);
        op_csr(32'h80C, 3'b010, 12'hC82, 6'd0, 32'h0, 6'd9); launch(32'h0, 1'b1, 1'b1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk_i);
        #1;
        chk("sb_drained", sb.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_unit.md
Name: memory_unit

Overview:
- Pipeline M stage, directly downstream of the execute stage.
- Consumes the EM_* pipeline register and performs:
  - store byte-lane/mask generation to data memory;
  - load extraction and sign/zero extension of the data word returned for the address issued in E;
  - CSR read/modify/write, including the fcsr/frm and cycle/instret counters.
- Registers the result into the MW_* pipeline register, which feeds writeback and E-stage forwarding.

Parameters:
- NOP, 32'h00000033, canonical bubble instruction (ADD x0,x0,x0).
- CNT_W, 64, width of the cycle and instret counters.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  async active-low reset.
- M_stall_i  in  1  hold the MW register; suppress side effects (store, CSR write, instret).
- W_flush_i  in  1  force a bubble into MW.
- EM_PC_i  in  32  instruction PC.
- EM_instr_i  in  32  raw instruction.
- EM_nop_i  in  1  bubble marker.
- EM_isLoad_i / EM_isStore_i / EM_isCSR_i  in  1  class flags.
- EM_rdId_i  in  6  destination register (bit5 = FP file).
- EM_rs1Id_i  in  6  rs1 index; bits[4:0] are zimm for CSRR*I.
- EM_csrId_i  in  12  CSR address.
- EM_funct3_i  in  3  load/store width or CSR op.
- EM_rs1_i  in  32  forwarded rs1 value (CSR write source).
- EM_rs2_i  in  32  store data.
- EM_Eresult_i  in  32  execute result.
- EM_addr_i  in  32  byte address.
- EM_Mdata_i  in  32  word read from data memory.
- EM_wbEnable_i  in  1  writeback request.
- DMemWAddr_o  out  32  store address: {EM_addr[31:2],2'b00}.
- DMemWData_o  out  32  lane-replicated store data.
- DMemWMask_o  out  4  byte write enables; 0 = no write.
- csrFRM_o  out  3  current frm, fed to execute.
- MW_PC_o  out  32  registered PC.
- MW_instr_o  out  32  registered instruction.
- MW_nop_o  out  1  registered bubble marker.
- MW_wbEnable_o  out  1  registered writeback enable.
- MW_rdId_o  out  6  registered destination.
- MW_wbData_o  out  32  registered writeback data.

Behaviour:
- Reset values (async on reset_i low): MW_instr_o=NOP, MW_nop_o=1, all other MW_* outputs 0, frm=0, fflags=0, cycle=0, instret=0. Reset mid-operation aborts everything; no partial store survives.
- Advance condition: adv = !M_stall_i && !EM_nop_i.

Store (combinational):
- Store is active when EM_isStore_i && adv.
- funct3 000 (SB): mask = 4'b0001 << addr[1:0]; data = {4{rs2[7:0]}}.
- funct3 001 (SH): mask = 4'b0011 << {addr[1],1'b0}; data = {2{rs2[15:0]}}.
- funct3 010 (SW): mask = 4'b1111; data = rs2.
- Otherwise, or store inactive: mask = 0.
- addr[0] is ignored for SH and addr[1:0] is ignored for SW; no misalignment trap.

Load (combinational):
- Byte is EM_Mdata_i >> (8*addr[1:0]); half is EM_Mdata_i >> (16*addr[1]).
- LB/LBU: sign/zero-extend the byte.
- LH/LHU: sign/zero-extend the half.
- LW: whole word.

CSR:
- Op is funct3[1:0]: 01 = RW, 10 = RS, 11 = RC. funct3[2] selects zimm = {27'b0, rs1Id[4:0]} instead of EM_rs1_i.
- RS/RC with a zero source performs no write.
- Read value is the pre-write value.
- CSR map:
  - 0x001 fflags [4:0].
  - 0x002 frm [2:0].
  - 0x003 fcsr = {24'b0, frm, fflags}.
  - 0xC00/0xC80 cycle lo/hi.
  - 0xC02/0xC82 instret lo/hi.
  - Unmapped addresses read 0 and ignore writes.
- cycle increments every clock. instret increments when adv is true.
- A CSR write wins over the same-cycle increment of the targeted counter half. The other half keeps the pre-increment value; carry from a written low half is dropped.
- Counters wrap at 2^64 to 0.

Writeback data:
- isLoad → load value; isCSR → CSR read value; else EM_Eresult_i.
- MW registers load when !M_stall_i.
- W_flush_i, which has priority over stall, loads the bubble: instr=NOP, nop=1, wbEnable=0.
- MW_wbEnable_o = EM_wbEnable_i && EM_rdId_i != 0.
- Latency: 1 clock, EM input to MW output.

Decomposition:
- Shared package rv_pkg: NOP constant, LOAD/STORE funct3 codes, CSR op codes, CSR address localparams.
- One sub-module, csr_file: holds frm, fflags, cycle and instret; combinational read port plus gated write port.
- memory_unit: load/store lane logic and the MW register.

Test Plan:
- SB rs2=0x000000A5 to addr 0x1003 → DMemWMask_o=1000, DMemWData_o=0xA5A5A5A5, DMemWAddr_o=0x1000.
- LH from addr 0x2002 with Mdata=0x8001_1234 → MW_wbData_o=0xFFFF8001. LHU → 0x00008001. LBU from addr 0x2001 → 0x00000012.
- CSRRW frm with rs1=5, then CSRRS fcsr with rs1=0 → csrFRM_o=5 on the next cycle; second read returns 0xA0; no write occurs.
- M_stall_i high for 3 cycles during a store → DMemWMask_o=0 while stalled, MW outputs frozen, instret unchanged; the write and instret+1 occur on release.
- W_flush_i and M_stall_i high together → MW_nop_o=1, MW_wbEnable_o=0, MW_instr_o=0x00000033.
- Write 0xFFFFFFFF to cycle lo, then the next clock → cycle lo=0 and cycle hi incremented; reset asserted mid-stream → all counters 0 and MW_nop_o=1 immediately.
